// File: rtl/conv_window_tracker.sv
// conv_window_tracker: raster-order pixel position tracker for the conv2d
// datapath. Flags each accepted pixel that completes a KxK window on the
// stride grid and reports that window's output coordinates, along with
// line-end and frame-end pulses. All outputs are registered.
module conv_window_tracker #(
    parameter int DATA_WIDTH  = 16,
    parameter int IMG_WIDTH   = 100,
    parameter int IMG_HEIGHT  = 100,
    parameter int KERNEL_SIZE = 3,
    parameter int STRIDE      = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Clear,
    input  logic                  En,
    output logic                  Win_Valid,
    output logic [DATA_WIDTH-1:0] Out_X,
    output logic [DATA_WIDTH-1:0] Out_Y,
    output logic                  Line_End,
    output logic                  Frame_End
);
    localparam logic [DATA_WIDTH-1:0] KM1 = DATA_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [DATA_WIDTH-1:0] SM1 = DATA_WIDTH'(STRIDE - 1);
    localparam logic [DATA_WIDTH-1:0] WM1 = DATA_WIDTH'(IMG_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] HM1 = DATA_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    // Position, stride phase and output-coordinate counters
    logic [DATA_WIDTH-1:0] col_q, col_d, row_q, row_d;
    logic [DATA_WIDTH-1:0] cph_q, cph_d, rph_q, rph_d;
    logic [DATA_WIDTH-1:0] xcnt_q, xcnt_d, ycnt_q, ycnt_d;

    // Registered outputs
    logic                  wv_q, wv_d, le_q, le_d, fe_q, fe_d;
    logic [DATA_WIDTH-1:0] ox_q, ox_d, oy_q, oy_d;

    logic hit_c, hit_r, last_col, last_row;

    // Phase is zero exactly at Col = K-1 + n*S, so a hit needs no divider
    assign hit_c    = (col_q >= KM1) && (cph_q == '0);
    assign hit_r    = (row_q >= KM1) && (rph_q == '0);
    assign last_col = (col_q == WM1);
    assign last_row = (row_q == HM1);

    // Next-state: Clear restarts the frame and drops any pixel offered with it
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        cph_d  = cph_q;
        rph_d  = rph_q;
        xcnt_d = xcnt_q;
        ycnt_d = ycnt_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        wv_d   = 1'b0;
        le_d   = 1'b0;
        fe_d   = 1'b0;
        if (Clear) begin
            col_d  = '0;
            row_d  = '0;
            cph_d  = '0;
            rph_d  = '0;
            xcnt_d = '0;
            ycnt_d = '0;
            ox_d   = '0;
            oy_d   = '0;
        end else if (En) begin
            wv_d = hit_c && hit_r;
            le_d = last_col;
            fe_d = last_col && last_row;
            if (hit_c && hit_r) begin
                ox_d = xcnt_q;
                oy_d = ycnt_q;
            end
            if (last_col) begin
                col_d  = '0;
                cph_d  = '0;
                xcnt_d = '0;
                if (last_row) begin
                    row_d  = '0;
                    rph_d  = '0;
                    ycnt_d = '0;
                end else begin
                    row_d = row_q + ONE;
                    if (row_q >= KM1)
                        rph_d = (rph_q == SM1) ? '0 : rph_q + ONE;
                    if (hit_r)
                        ycnt_d = ycnt_q + ONE;
                end
            end else begin
                col_d = col_q + ONE;
                if (col_q >= KM1)
                    cph_d = (cph_q == SM1) ? '0 : cph_q + ONE;
                if (hit_c && hit_r)
                    xcnt_d = xcnt_q + ONE;
            end
        end
    end

    // State register; Rst yields the same state as Clear
    always_ff @(posedge Clk) begin
        if (Rst) begin
            col_q  <= '0;
            row_q  <= '0;
            cph_q  <= '0;
            rph_q  <= '0;
            xcnt_q <= '0;
            ycnt_q <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            wv_q   <= 1'b0;
            le_q   <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            cph_q  <= cph_d;
            rph_q  <= rph_d;
            xcnt_q <= xcnt_d;
            ycnt_q <= ycnt_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            wv_q   <= wv_d;
            le_q   <= le_d;
            fe_q   <= fe_d;
        end
    end

    assign Win_Valid = wv_q;
    assign Out_X     = ox_q;
    assign Out_Y     = oy_q;
    assign Line_End  = le_q;
    assign Frame_End = fe_q;

endmodule
